// File: rtl/array_serializer_ctrl_if.sv
// rtl/array_serializer_ctrl_if.sv - handshake bundle between packed producer, serializer and element consumer
interface array_serializer_ctrl_if #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8
);
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic [COLS*BIT_WIDTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [BIT_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]          out_index;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      flush;
  logic                      busy;

  // serializer side
  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_index, out_last, out_valid, busy
  );

  // producer/consumer side
  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_index, out_last, out_valid, busy
  );
endinterface

// File: rtl/array_serializer_ctrl.sv
// rtl/array_serializer_ctrl.sv - streams one packed array word out one element per beat
module array_serializer_ctrl #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8,
  parameter int REVERSE   = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  array_serializer_ctrl_if.slave bus
);
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IDX_W-1:0] START_IDX = (REVERSE != 0) ? IDX_W'(COLS - 1) : '0;
  localparam logic [IDX_W-1:0] FINAL_IDX = (REVERSE != 0) ? '0 : IDX_W'(COLS - 1);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t                    state, state_nxt;
  logic [COLS*BIT_WIDTH-1:0] held_word, held_word_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [BIT_WIDTH-1:0]      elem_sel;
  logic                      out_valid_int;
  logic                      at_final;
  logic                      beat;
  logic                      capture;
  logic                      in_ready_int;

  assign out_valid_int = (state == STREAM);
  assign at_final      = (idx == FINAL_IDX);
  assign beat          = out_valid_int & bus.out_ready;

  // The last-beat term lets the next word be taken in the same cycle the
  // current one finishes, so consecutive words stream with no bubble.
  assign in_ready_int  = rst_n & ~bus.flush &
                         ((state == IDLE) | (beat & at_final));
  assign capture       = bus.in_valid & in_ready_int;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.busy      = out_valid_int;
  assign bus.out_last  = out_valid_int & at_final;
  assign bus.out_index = idx;
  assign bus.out_data  = elem_sel;

  // Element mux from the held word; compare-based so any COLS lints cleanly.
  always_comb begin
    elem_sel = '0;
    for (int i = 0; i < COLS; i++) begin
      if (idx == IDX_W'(i)) elem_sel = held_word[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Next state: flush beats capture, capture beats a plain beat advance.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    held_word_nxt = held_word;
    if (bus.flush) begin
      state_nxt = IDLE;
      idx_nxt   = START_IDX;
    end else if (capture) begin
      state_nxt     = STREAM;
      idx_nxt       = START_IDX;
      held_word_nxt = bus.in_data;
    end else if (beat) begin
      if (at_final) begin
        state_nxt = IDLE;
        idx_nxt   = START_IDX;
      end else if (REVERSE != 0) begin
        idx_nxt = idx - IDX_W'(1);
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end
  end

  // State, index and held word registers; reset drops the word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      held_word <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      held_word <= held_word_nxt;
    end
  end
endmodule
